// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, queued MDU
// results drain into free slots, stale queued writes are squashed.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_wdata,
  output logic                     rf_src,
  output logic                     stall_req,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] LIM  = WW'(STARVE_LIMIT);

  logic          vld_q  [DEPTH];
  logic          vld_d  [DEPTH];
  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;
  logic [31:0]   busy_q, busy_d;

  logic pw, head_in, head_vld, pop, push;

  always_comb begin
    pw        = wb_we && (wb_rd != 5'd0);
    head_in   = (cnt_q != '0);
    head_vld  = head_in && vld_q[rptr_q];
    mdu_ready = (cnt_q < FULL);
    // A squashed head leaves without a write, even under pipeline traffic.
    pop       = head_in && !(head_vld && pw);
    push      = mdu_valid && mdu_ready && (mdu_rd != 5'd0)
                && !(pw && (mdu_rd == wb_rd));

    rf_we    = 1'b0;
    rf_src   = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = 32'd0;
    if (pw) begin
      rf_we    = 1'b1;
      rf_rd    = wb_rd;
      rf_wdata = wb_data;
    end else if (head_vld) begin
      rf_we    = 1'b1;
      rf_src   = 1'b1;
      rf_rd    = rd_q[rptr_q];
      rf_wdata = data_q[rptr_q];
    end

    vld_d  = vld_q;
    rd_d   = rd_q;
    data_d = data_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pw && (rd_q[i] == wb_rd)) vld_d[i] = 1'b0;
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wptr_q]  = 1'b1;
      rd_d[wptr_q]   = mdu_rd;
      data_d[wptr_q] = mdu_data;
      wptr_d         = wptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[rd_d[i]] = busy_d[rd_d[i]] | vld_d[i];
    end

    wait_d = '0;
    if (head_vld && pw && (rd_q[rptr_q] != wb_rd)) begin
      wait_d = (wait_q == LIM) ? LIM : wait_q + WW'(1);
    end
    stall_d = (wait_d == LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end

  assign stall_req = stall_q;
  assign busy_mask = busy_q;
  assign q_count   = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: pass-through vector table, queue scoreboard,
// and hand-written backpressure/squash/starvation/reset sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic        stall_req;
  logic [31:0] busy_mask;
  logic [1:0]  q_count;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_src(rf_src),
    .stall_req(stall_req), .busy_mask(busy_mask), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  wr_t sb[$];
  int  n_pass = 0;
  int  n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Every queue-sourced RF write must match the oldest expected MDU result.
  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1 && rf_src === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_q_write_rd", 32'(rf_rd), 32'h0);
        n_pass--;
        if (rf_rd == 5'd0) $display("FAIL unexpected_q_write: rd 0");
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("sb_rd", 32'(rf_rd), 32'(w.rd));
        chk("sb_data", rf_wdata, w.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    mdu_valid = v;
    mdu_rd    = rd;
    mdu_data  = d;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd,
                    input logic [31:0] d);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = d;
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 32'h00000001};
    vt[2] = '{1'b0, 5'd7,  32'h00000055, 1'b0, 5'd0,  32'h0};
    vt[3] = '{1'b1, 5'd0,  32'h00000077, 1'b0, 5'd0,  32'h0};

    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      wb(vt[i].we, vt[i].rd, vt[i].data);
      #1;
      chk("pt_we", 32'(rf_we), 32'(vt[i].e_we));
      chk("pt_rd", 32'(rf_rd), 32'(vt[i].e_rd));
      chk("pt_data", rf_wdata, vt[i].e_data);
      chk("pt_src", 32'(rf_src), 32'd0);
      tick();
    end

    // Drain into bubble, no input-to-RF bypass
    wb(1'b0, 5'd0, 32'd0);
    mdu(1'b1, 5'd7, 32'h12345678);
    sb.push_back('{5'd7, 32'h12345678});
    #1;
    chk("drain_nobypass", 32'(rf_we), 32'd0);
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    chk("drain_cnt1", 32'(q_count), 32'd1);
    chk("drain_busy", busy_mask, 32'h80);
    chk("drain_we", 32'(rf_we), 32'd1);
    chk("drain_rd", 32'(rf_rd), 32'd7);
    chk("drain_src", 32'(rf_src), 32'd1);
    tick();
    chk("drain_cnt0", 32'(q_count), 32'd0);
    chk("drain_busy0", busy_mask, 32'd0);

    // Full / backpressure
    wb(1'b1, 5'd10, 32'hAAAA0000);
    mdu(1'b1, 5'd3, 32'h33);
    sb.push_back('{5'd3, 32'h33});
    tick();
    mdu(1'b1, 5'd4, 32'h44);
    #1;
    chk("full_ready1", 32'(mdu_ready), 32'd1);
    sb.push_back('{5'd4, 32'h44});
    tick();
    mdu(1'b1, 5'd6, 32'h66);
    chk("full_cnt", 32'(q_count), 32'd2);
    chk("full_ready0", 32'(mdu_ready), 32'd0);
    chk("full_busy", busy_mask, 32'h18);
    chk("full_src", 32'(rf_src), 32'd0);
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    chk("full_hold", 32'(q_count), 32'd2);
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("full_pop_ready", 32'(mdu_ready), 32'd0);
    chk("full_d1_rd", 32'(rf_rd), 32'd3);
    tick();
    chk("full_d2_rd", 32'(rf_rd), 32'd4);
    chk("full_d2_ready", 32'(mdu_ready), 32'd1);
    tick();
    chk("full_cnt0", 32'(q_count), 32'd0);

    // Squash
    wb(1'b1, 5'd10, 32'h1);
    mdu(1'b1, 5'd9, 32'h99);
    tick();
    chk("sq_busy9", busy_mask, 32'h200);
    wb(1'b1, 5'd9, 32'h9999);
    mdu(1'b1, 5'd9, 32'h999);
    #1;
    chk("sq_ready", 32'(mdu_ready), 32'd1);
    chk("sq_pw_rd", 32'(rf_rd), 32'd9);
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    chk("sq_busy0", busy_mask, 32'd0);
    chk("sq_cnt", 32'(q_count), 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("sq_nowrite", 32'(rf_we), 32'd0);
    tick();
    chk("sq_cnt0", 32'(q_count), 32'd0);

    // Starvation
    wb(1'b1, 5'd10, 32'h2);
    mdu(1'b1, 5'd12, 32'hC);
    sb.push_back('{5'd12, 32'hC});
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    tick();
    chk("starve_c4", 32'(stall_req), 32'd0);
    tick();
    chk("starve_c5", 32'(stall_req), 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("starve_grant", 32'(rf_src), 32'd1);
    tick();
    chk("starve_clear", 32'(stall_req), 32'd0);
    chk("starve_cnt0", 32'(q_count), 32'd0);

    // Async reset with entries queued
    wb(1'b1, 5'd10, 32'h3);
    mdu(1'b1, 5'd20, 32'h20);
    tick();
    mdu(1'b1, 5'd21, 32'h21);
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    chk("pre_rst_cnt", 32'(q_count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(q_count), 32'd0);
    chk("arst_busy", busy_mask, 32'd0);
    chk("arst_ready", 32'(mdu_ready), 32'd1);
    chk("arst_rf_rd", 32'(rf_rd), 32'd10);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    tick();

    // x0 pipeline write leaves the slot to the queue
    wb(1'b1, 5'd10, 32'h4);
    mdu(1'b1, 5'd17, 32'h1717);
    sb.push_back('{5'd17, 32'h1717});
    tick();
    mdu(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd0, 32'h5);
    #1;
    chk("x0_we", 32'(rf_we), 32'd1);
    chk("x0_rd", 32'(rf_rd), 32'd17);
    chk("x0_src", 32'(rf_src), 32'd1);
    tick();
    chk("x0_cnt0", 32'(q_count), 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Register-file write-port arbiter placed after the writeback stage. It shares the single RF write port between the in-order pipeline writeback, which has absolute priority, and results returned by a long-latency unit (MDU, divider). MDU results are buffered in a small in-order queue and drained into free writeback slots. Queued writes made stale by younger pipeline writes to the same register are squashed. A starvation timer requests a pipeline bubble when the queue head waits too long.

## Interface
Parameters:
- DEPTH, 2: queue entries (power of two, ≥2)
- STARVE_LIMIT, 4: cycles the queue head may wait before stall_req is raised (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_we  in  1  pipeline RF write enable, from the writeback stage
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data (ALU or load result)
- mdu_valid  in  1  MDU result valid
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  queue can accept; transfer occurs when mdu_valid && mdu_ready
- rf_we  out  1  RF write enable
- rf_rd  out  5  RF write address
- rf_wdata  out  32  RF write data
- rf_src  out  1  0 = pipeline, 1 = queue
- stall_req  out  1  registered request for a one-slot pipeline writeback bubble
- busy_mask  out  32  bit r set while a valid queued write to xr is pending
- q_count  out  $clog2(DEPTH)+1  occupied queue slots, including squashed slots

## Operation
- pw = wb_we && wb_rd != 0. x0 pipeline writes count as no write and do not consume the slot.
- Grant, combinational:
  - If pw: rf_we=1, rf_src=0, and rf_rd/rf_wdata come from wb_*.
  - Otherwise, if the head is valid: rf_we=1, rf_src=1, and rf_rd/rf_wdata come from the head; the head pops at the edge.
  - Otherwise: rf_we=0, rf_src=0, rf_rd=0, rf_wdata=0.
- Invalid (squashed) head: popped at the next edge regardless of pw, with no RF write.
- Enqueue:
  - mdu_ready = (q_count < DEPTH), computed from current occupancy only. A pop in the same cycle does not free a slot early.
  - An accepted entry with mdu_rd == 0 is dropped and not enqueued.
- Squash:
  - When pw, every queued entry with rd == wb_rd has its valid bit cleared at the edge.
  - A same-cycle incoming MDU result with mdu_rd == wb_rd is accepted, and mdu_ready is still honoured, but it is not enqueued. The pipeline write is always treated as the younger one.
- Order: queue entries drain strictly FIFO. The pipeline never reorders relative to them except by the squash rule.
- busy_mask: OR of one-hot(rd) over valid queue entries. It is registered state, updated at the same edge as the queue.
- Starvation:
  - wait_cnt increments each cycle the head is valid and not granted, and saturates at STARVE_LIMIT.
  - wait_cnt clears when the head pops or is squashed.
  - stall_req = (wait_cnt == STARVE_LIMIT).
- Simultaneous push and pop when not full: both occur, and q_count is unchanged.

## Timing
- Reset (async, immediate):
  - Queue empty, all valid bits 0, q_count=0, wait_cnt=0, stall_req=0, busy_mask=0, mdu_ready=1.
  - rf_* follow wb_* combinationally.
- A reset asserted mid-operation discards all queued results with no RF writes.
- Enqueue-to-write latency: minimum 1 cycle. An entry accepted at edge N can drive rf_we no earlier than cycle N+1. There is no input-to-RF bypass.
- Pipeline write latency: 0 cycles (combinational pass-through).
- stall_req rises the cycle after the head's STARVE_LIMIT-th ungranted cycle. It falls the cycle after the head pops.
- If pw stays high while stall_req=1, the pipeline still wins. The design remains correct, only the queue is delayed.
- Full queue: mdu_ready=0 for the whole cycle, including a cycle in which the head pops.

## Test plan
- Idle pass-through: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, queue empty -> rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, rf_src=0 in the same cycle.
- Drain into bubble: MDU pushes rd=7, data=0x12345678 at edge N, wb_we=0 at N+1 -> at N+1 rf_we=1, rf_rd=7, rf_src=1; q_count=0 and busy_mask=0 after edge N+1.
- Full/backpressure: DEPTH=2, wb_we=1 continuously, MDU pushes rd=3 then rd=4 -> q_count=2, mdu_ready=0, busy_mask=0x18. Drop wb_we -> rd=3 is written, then rd=4 on the next cycle.
- Squash: queue holds rd=9, then the pipeline writes rd=9 -> busy_mask bit 9 clears. The head is later popped with no RF write of 9. A same-cycle MDU rd=9 with wb_rd=9 is accepted with q_count unchanged.
- Starvation: STARVE_LIMIT=4, queue head valid, wb_we=1 held -> stall_req=1 on the 5th cycle. Release wb_we for one cycle -> head written and stall_req=0 the next cycle.
- Reset/x0: async rst with 2 entries queued -> outputs reach reset values immediately, with no subsequent rf_we from the queue. A wb_we=1 with wb_rd=0 lets a queued entry drain in that cycle.
